// File: rtl/deserializer8_rtl.sv
// Collects eight consecutive words from a valid/ready input stream and presents
// them together as one frame on eight parallel output slots.
module deserializer8_rtl #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in_msg,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out0,
    output logic [p_nbits-1:0] out1,
    output logic [p_nbits-1:0] out2,
    output logic [p_nbits-1:0] out3,
    output logic [p_nbits-1:0] out4,
    output logic [p_nbits-1:0] out5,
    output logic [p_nbits-1:0] out6,
    output logic [p_nbits-1:0] out7,
    output logic [2:0]         count
);

    // state | meaning
    // FILL  | accepting words into slot[count]
    // FULL  | frame complete, waiting for the consumer
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [2:0]         count_q, count_d;
    logic [p_nbits-1:0] slot_q [8];
    logic [7:0]         slot_we;
    logic               in_xfer;
    logic               out_xfer;

    // Handshake outputs depend only on the state register.
    assign in_rdy   = (state_q == ST_FILL);
    assign out_val  = (state_q == ST_FULL);
    assign in_xfer  = in_val && in_rdy;
    assign out_xfer = out_val && out_rdy;
    assign slot_we  = in_xfer ? (8'(1) << count_q) : 8'd0;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (in_xfer) begin
            count_d = count_q + 3'd1;
            if (count_q == 3'd7) begin
                state_d = ST_FULL;
            end
        end else if (out_xfer) begin
            state_d = ST_FILL;
            count_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FILL;
            count_q <= 3'd0;
            for (int k = 0; k < 8; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            for (int k = 0; k < 8; k++) begin
                if (slot_we[k]) begin
                    slot_q[k] <= in_msg;
                end
            end
        end
    end

    assign count = count_q;
    assign out0  = slot_q[0];
    assign out1  = slot_q[1];
    assign out2  = slot_q[2];
    assign out3  = slot_q[3];
    assign out4  = slot_q[4];
    assign out5  = slot_q[5];
    assign out6  = slot_q[6];
    assign out7  = slot_q[7];

endmodule

// File: tb/tb_deserializer8_rtl.sv
// Drives three widths (32, 5, 1) of the deserializer in lockstep from one
// stimulus stream and checks each against masked expected frames.
module tb_deserializer8_rtl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_val;
    logic        out_rdy;
    logic [31:0] in_msg;

    logic        rdy32, val32, rdy5, val5, rdy1, val1;
    logic [2:0]  cnt32, cnt5, cnt1;
    logic [31:0] o32 [8];
    logic [4:0]  o5  [8];
    logic [0:0]  o1  [8];

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_f [8];

    always #5 clk = ~clk;

    deserializer8_rtl #(.p_nbits(32)) u_d32 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy32), .in_msg(in_msg),
        .out_val(val32), .out_rdy(out_rdy),
        .out0(o32[0]), .out1(o32[1]), .out2(o32[2]), .out3(o32[3]),
        .out4(o32[4]), .out5(o32[5]), .out6(o32[6]), .out7(o32[7]), .count(cnt32)
    );

    deserializer8_rtl #(.p_nbits(5)) u_d5 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy5), .in_msg(in_msg[4:0]),
        .out_val(val5), .out_rdy(out_rdy),
        .out0(o5[0]), .out1(o5[1]), .out2(o5[2]), .out3(o5[3]),
        .out4(o5[4]), .out5(o5[5]), .out6(o5[6]), .out7(o5[7]), .count(cnt5)
    );

    deserializer8_rtl #(.p_nbits(1)) u_d1 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy1), .in_msg(in_msg[0:0]),
        .out_val(val1), .out_rdy(out_rdy),
        .out0(o1[0]), .out1(o1[1]), .out2(o1[2]), .out3(o1[3]),
        .out4(o1[4]), .out5(o1[5]), .out6(o1[6]), .out7(o1[7]), .count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic rdy, input logic val, input logic [2:0] cnt);
        chk({tag, " in_rdy32"},  {31'd0, rdy32}, {31'd0, rdy});
        chk({tag, " out_val32"}, {31'd0, val32}, {31'd0, val});
        chk({tag, " count32"},   {29'd0, cnt32}, {29'd0, cnt});
        chk({tag, " in_rdy5"},   {31'd0, rdy5},  {31'd0, rdy});
        chk({tag, " out_val5"},  {31'd0, val5},  {31'd0, val});
        chk({tag, " count5"},    {29'd0, cnt5},  {29'd0, cnt});
        chk({tag, " in_rdy1"},   {31'd0, rdy1},  {31'd0, rdy});
        chk({tag, " out_val1"},  {31'd0, val1},  {31'd0, val});
        chk({tag, " count1"},    {29'd0, cnt1},  {29'd0, cnt});
    endtask

    task automatic chk_frame(input string tag);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s w32 slot%0d", tag, k), o32[k], exp_f[k]);
            chk($sformatf("%s w5 slot%0d", tag, k), {27'd0, o5[k]}, exp_f[k] & 32'h1F);
            chk($sformatf("%s w1 slot%0d", tag, k), {31'd0, o1[k]}, exp_f[k] & 32'h1);
        end
    endtask

    task automatic set_frame(input logic [31:0] base, input logic [31:0] step);
        for (int k = 0; k < 8; k++) begin
            exp_f[k] = base + step * k;
        end
    endtask

    // Sends 8 words base, base+1, ... on consecutive cycles, checking count.
    task automatic send8(input string tag, input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            in_val = 1'b1;
            in_msg = base + 32'(i);
            tick();
            chk({tag, " count"}, {29'd0, cnt32}, 32'((i + 1) % 8));
        end
        in_val = 1'b0;
    endtask

    initial begin : main
        bit          m_full;
        logic [2:0]  m_cnt;
        int          frames;
        int          cycles;
        logic        v, r;

        reset = 1'b1; in_val = 1'b0; out_rdy = 1'b0; in_msg = 32'd0;
        tick();
        // reset state
        chk_ctl("reset", 1'b1, 1'b0, 3'd0);
        set_frame(32'd0, 32'd0);
        chk_frame("reset");

        // basic fill: 1..8
        reset = 1'b0;
        send8("fill", 32'd1);
        chk_ctl("fill done", 1'b0, 1'b1, 3'd0);
        set_frame(32'd1, 32'd1);
        chk_frame("fill");

        // backpressure: FULL ignores inputs while out_rdy=0
        in_val = 1'b1; in_msg = 32'hFF; out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_ctl("bp hold", 1'b0, 1'b1, 3'd0);
            chk_frame("bp hold");
        end
        out_rdy = 1'b1;
        tick();
        chk_ctl("bp release", 1'b1, 1'b0, 3'd0);
        chk_frame("bp release");

        // out_rdy ignored in FILL
        in_val = 1'b0;
        tick();
        chk_ctl("fill ordy", 1'b1, 1'b0, 3'd0);
        out_rdy = 1'b0;

        // bubbles between words
        for (int i = 0; i < 8; i++) begin
            in_val = 1'b1;
            in_msg = 32'hA0 + 32'(i);
            tick();
            chk("bubble count", {29'd0, cnt32}, 32'((i + 1) % 8));
            in_val = 1'b0;
            in_msg = 32'h55;
            tick();
            chk("bubble hold", {29'd0, cnt32}, 32'((i + 1) % 8));
        end
        chk_ctl("bubble done", 1'b0, 1'b1, 3'd0);
        set_frame(32'hA0, 32'd1);
        chk_frame("bubble");
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk_ctl("bubble drain", 1'b1, 1'b0, 3'd0);

        // mid-frame reset, with a competing in_val on the reset edge
        for (int i = 0; i < 3; i++) begin
            in_val = 1'b1;
            in_msg = 32'hC0 + 32'(i);
            tick();
        end
        chk("midrst pre count", {29'd0, cnt32}, 32'd3);
        reset = 1'b1; in_val = 1'b1; in_msg = 32'hEE; out_rdy = 1'b1;
        tick();
        reset = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
        chk_ctl("midrst", 1'b1, 1'b0, 3'd0);
        set_frame(32'd0, 32'd0);
        chk_frame("midrst clear");
        send8("midrst refill", 32'hD0);
        chk_ctl("midrst refill done", 1'b0, 1'b1, 3'd0);
        set_frame(32'hD0, 32'd1);
        chk_frame("midrst refill");

        // wrap: out_rdy held high, back-to-back frames
        out_rdy = 1'b1;
        tick();
        chk_ctl("wrap start", 1'b1, 1'b0, 3'd0);
        send8("wrap f1", 32'h10);
        chk_ctl("wrap f1 done", 1'b0, 1'b1, 3'd0);
        set_frame(32'h10, 32'd1);
        chk_frame("wrap f1");
        in_val = 1'b1; in_msg = 32'h99;
        tick();
        chk_ctl("wrap gap", 1'b1, 1'b0, 3'd0);
        send8("wrap f2", 32'h20);
        chk_ctl("wrap f2 done", 1'b0, 1'b1, 3'd0);
        set_frame(32'h20, 32'd1);
        chk_frame("wrap f2");

        // random frames across all widths
        reset = 1'b1; in_val = 1'b0; out_rdy = 1'b0;
        tick();
        reset = 1'b0;
        m_full = 1'b0; m_cnt = 3'd0; frames = 0; cycles = 0;
        set_frame(32'd0, 32'd0);
        while (frames < 50 && cycles < 20000) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            in_val = v; out_rdy = r; in_msg = $urandom;
            if (!m_full && v) begin
                exp_f[m_cnt] = in_msg;
                if (m_cnt == 3'd7) m_full = 1'b1;
                m_cnt = m_cnt + 3'd1;
            end else if (m_full && r) begin
                m_full = 1'b0;
                m_cnt  = 3'd0;
                frames++;
            end
            tick();
            cycles++;
            chk("rand out_val", {31'd0, val32}, {31'd0, m_full});
            chk("rand count", {29'd0, cnt32}, {29'd0, m_cnt});
            if (m_full) begin
                chk_frame("rand frame");
            end
        end
        chk("rand frames done", 32'(frames), 32'd50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
